// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: round-robin sharing of one fp16 divider among N_REQ lanes.
// Sequences the divider through clear/start/wait and tags each quotient.
module fdiv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 div_reset,
  output logic                 div_enable,
  output logic [15:0]          div_f1,
  output logic [15:0]          div_f2,
  input  logic [15:0]          div_f,
  input  logic                 div_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_cur_id;
  logic [ID_W-1:0]  r_resp_id;
  logic [15:0]      r_op_a;
  logic [15:0]      r_op_b;
  logic [15:0]      r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_timeout;
  logic [15:0]      w_a;
  logic [15:0]      w_b;
  int               w_j;

  // Scan upward from r_ptr, wrapping, and take the first valid requester.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = 0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_idx = ID_W'(w_j);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == w_win) begin
        w_a = req_a[16*k +: 16];
        w_b = req_b[16*k +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_CLR;
      S_CLR:   w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          w_next = S_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_next    = S_RESP;
          w_timeout = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cur_id  <= '0;
      r_resp_id <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_op_a   <= w_a;
        r_op_b   <= w_b;
        r_cur_id <= w_win;
      end
      if (r_state == S_START) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        if (div_done) begin
          r_data    <= div_f;
          r_err     <= 1'b0;
          r_resp_id <= r_cur_id;
        end else if (w_timeout) begin
          r_data    <= 16'h7E00;
          r_err     <= 1'b1;
          r_resp_id <= r_cur_id;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == S_RESP) begin
        if (r_cur_id == ID_W'(N_REQ - 1)) r_ptr <= '0;
        else r_ptr <= r_cur_id + ID_W'(1);
      end
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_data;
  assign resp_err   = r_err;
  assign busy       = (r_state != S_IDLE);
  assign div_reset  = reset | (r_state == S_CLR);
  assign div_enable = (r_state == S_START);
  assign div_f1     = r_op_a;
  assign div_f2     = r_op_b;

endmodule
